// File: rtl/dota_pkg.sv
// -----------------------------------------------------------------------------
// dota_pkg
// Shared types and helpers for the OTA/comparator density meter.
//   - dota_meas_state_t : measurement FSM states
//   - TOG_MAX           : saturation ceiling of the transition counter
//   - sat_shift()       : scales the ones count down to the result width, clamped
//   - maj3()            : 2-of-3 majority vote used by the optional glitch filter
// -----------------------------------------------------------------------------
package dota_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } dota_meas_state_t;

    localparam logic [7:0] TOG_MAX = 8'hFF;

    // Shift the window ones count down to the result width and clamp to the
    // largest representable value, so a window of all ones reads full scale
    // instead of wrapping to zero.
    function automatic logic [31:0] sat_shift(
        input logic [31:0] ones,
        input int unsigned shift,
        input int unsigned out_w
    );
        logic [31:0] shifted;
        logic [31:0] max_val;
        shifted = ones >> shift;
        max_val = (32'd1 << out_w) - 32'd1;
        if (shifted > max_val) begin
            return max_val;
        end else begin
            return shifted;
        end
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/dota_sync.sv
// -----------------------------------------------------------------------------
// dota_sync
// Brings the asynchronous comparator pin into the clk domain and, optionally,
// removes single-cycle pulses from it.
//
// Optional feature macro: DOTA_GLITCH_FILTER_EN
//   defined   : clean = registered majority of three consecutive synchronised
//               samples (two extra cycles of latency, 1-cycle pulses rejected)
//   undefined : clean = last synchroniser stage, no filter flops
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   cmp_in in  1  raw comparator output (asynchronous to clk)
//   clean  out 1  synchronised (and optionally filtered) comparator bit
// -----------------------------------------------------------------------------
module dota_sync
    import dota_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmp_in,
    output logic clean
);

    // The pad has a pull, so a floating pin arrives as a defined 0 here.
    logic [SYNC_STAGES-1:0] sync_r;

    // Synchroniser chain: cmp_in enters stage 0, s is the top stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], cmp_in};
        end
    end

`ifdef DOTA_GLITCH_FILTER_EN
    logic s_d1_r;
    logic s_d2_r;
    logic filt_r;

    // Filter history and registered vote; history starts at 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d1_r <= 1'b0;
            s_d2_r <= 1'b0;
            filt_r <= 1'b0;
        end else begin
            s_d1_r <= sync_r[SYNC_STAGES-1];
            s_d2_r <= s_d1_r;
            filt_r <= maj3(sync_r[SYNC_STAGES-1], s_d1_r, s_d2_r);
        end
    end

    assign clean = filt_r;
`else
    assign clean = sync_r[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/dota_density_meter.sv
// -----------------------------------------------------------------------------
// dota_density_meter
// Measures the ones-density and transition count of the OTA comparator output
// over a window of 2^WIN_LOG2 synchronised samples and publishes both as
// registered results with a one-cycle valid strobe.
//
// Optional feature macro: DOTA_GLITCH_FILTER_EN (majority filter in dota_sync).
//
// Ports:
//   clk      in  1      system clock
//   rst_n    in  1      asynchronous active-low reset
//   ena      in  1      block enable; low aborts a measurement in progress
//   cmp_in   in  1      raw comparator output, asynchronous to clk
//   start    in  1      single-cycle request for one measurement
//   cont     in  1      back-to-back windows while high
//   density  out OUT_W  last completed window's scaled ones-density
//   toggles  out 8      last completed window's transition count (saturating)
//   valid    out 1      one-cycle strobe when density/toggles update
//   busy     out 1      high in SETTLE, MEASURE and DONE
// -----------------------------------------------------------------------------
module dota_density_meter
    import dota_pkg::*;
#(
    parameter int WIN_LOG2    = 8,
    parameter int OUT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmp_in,
    input  logic             start,
    input  logic             cont,
    output logic [OUT_W-1:0] density,
    output logic [7:0]       toggles,
    output logic             valid,
    output logic             busy
);

    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic                NO_SETTLE   = (SETTLE_CYC == 0) ? 1'b1 : 1'b0;
    localparam logic [WIN_LOG2-1:0] SAMPLE_LAST = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] SAMPLE_ONE  = WIN_LOG2'(1);

    dota_meas_state_t    state_r;
    dota_meas_state_t    state_s;

    logic                clean_s;
    logic [3:0]          settle_cnt_r;
    logic [WIN_LOG2-1:0] sample_cnt_r;
    logic [WIN_LOG2:0]   ones_r;
    logic [WIN_LOG2:0]   ones_s;
    logic [7:0]          tog_cnt_r;
    logic [7:0]          tog_s;
    logic                prev_r;

    logic                publish_s;
    logic                busy_s;

    logic [OUT_W-1:0]    density_r;
    logic [7:0]          toggles_r;
    logic                valid_r;
    logic                busy_r;

    dota_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp_in(cmp_in),
        .clean (clean_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; ena low from any active state aborts to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ena && (start || cont)) begin
                    if (NO_SETTLE) begin
                        state_s = MEASURE;
                    end else begin
                        state_s = SETTLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                if (!ena) begin
                    state_s = IDLE;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = MEASURE;
                end else begin
                    state_s = SETTLE;
                end
            end
            MEASURE: begin
                if (!ena) begin
                    state_s = IDLE;
                end else if (sample_cnt_r == SAMPLE_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = MEASURE;
                end
            end
            DONE: begin
                // Continuous mode re-enters MEASURE directly: no re-settle.
                if (ena && cont) begin
                    state_s = MEASURE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM output decode: publish on the final sample, busy for any active state.
    always_comb begin
        publish_s = 1'b0;
        busy_s    = 1'b0;
        if ((state_r == MEASURE) && (state_s == DONE)) begin
            publish_s = 1'b1;
        end else begin
            publish_s = 1'b0;
        end
        if (state_s != IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // Running totals including the current sample.
    always_comb begin
        ones_s = ones_r + {{WIN_LOG2{1'b0}}, clean_s};
        if ((clean_s != prev_r) && (tog_cnt_r != TOG_MAX)) begin
            tog_s = tog_cnt_r + 8'd1;
        end else begin
            tog_s = tog_cnt_r;
        end
    end

    // Settle, sample, ones and toggle counters.
    // prev follows the clean bit every cycle, so on the first MEASURE cycle it
    // already holds the sample taken on the cycle before the window opened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= 4'd0;
            sample_cnt_r <= {WIN_LOG2{1'b0}};
            ones_r       <= {(WIN_LOG2 + 1){1'b0}};
            tog_cnt_r    <= 8'd0;
            prev_r       <= 1'b0;
        end else begin
            prev_r <= clean_s;
            if ((state_r == SETTLE) && (state_s == SETTLE)) begin
                settle_cnt_r <= settle_cnt_r + 4'd1;
            end else begin
                settle_cnt_r <= 4'd0;
            end
            if ((state_r == MEASURE) && (state_s == MEASURE)) begin
                ones_r       <= ones_s;
                tog_cnt_r    <= tog_s;
                sample_cnt_r <= sample_cnt_r + SAMPLE_ONE;
            end else begin
                ones_r       <= {(WIN_LOG2 + 1){1'b0}};
                tog_cnt_r    <= 8'd0;
                sample_cnt_r <= {WIN_LOG2{1'b0}};
            end
        end
    end

    // Result registers: load with the final sample folded in, so the update
    // and the valid strobe appear together on the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            density_r <= {OUT_W{1'b0}};
            toggles_r <= 8'd0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            busy_r <= busy_s;
            if (publish_s) begin
                density_r <= OUT_W'(sat_shift(32'(ones_s), WIN_LOG2 - OUT_W, OUT_W));
                toggles_r <= tog_s;
                valid_r   <= 1'b1;
            end else begin
                valid_r   <= 1'b0;
            end
        end
    end

    assign density = density_r;
    assign toggles = toggles_r;
    assign valid   = valid_r;
    assign busy    = busy_r;

endmodule
